// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven on mult_div_unit.op
//   - default busy latencies for multiply and divide
//   - FSM state enumeration
//   - pending-result record and a small helper for counter sizing
package mdu_pkg;

    // Operation codes; values 6 and 7 are undefined and treated as no-ops.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } mdu_state_e;

    // Result captured at issue time and committed when busy falls.
    // wr is cleared for divide-by-zero so HI/LO are left untouched.
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit.
//
// A start in IDLE issues op. MULT/MULTU and DIV/DIVU compute their result
// combinationally at the issue edge into a pending register, then hold busy
// for MULT_CYCLES / DIV_CYCLES cycles; HI/LO are written on the edge where
// busy falls. MTHI/MTLO write A directly at the issue edge with no busy time.
// Starts seen while busy are dropped.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous active-high reset (priority over start)
//   start  in   1   one-cycle issue request, sampled only in IDLE
//   op     in   3   operation code (mdu_op_e)
//   A      in  32   first operand / dividend / MTHI-MTLO data
//   B      in  32   second operand / divisor
//   busy   out  1   high while a multiply or divide is in flight
//   HI     out 32   HI register
//   LO     out 32   LO register
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = imax(MULT_CYCLES, DIV_CYCLES);
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mdu_state_e     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    mdu_res_t       pend, pend_nxt;
    logic [31:0]    hi_q, hi_nxt;
    logic [31:0]    lo_q, lo_nxt;

    // ---------------- combinational arithmetic ----------------
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 when B==0 so the dividers never see zero; the
    // result is discarded in that case anyway.
    logic        div_zero;
    logic [31:0] b_safe;
    assign div_zero = (B == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : B;

    // Signed divide done on magnitudes. Quotient sign is the xor of operand
    // signs (truncation toward zero), remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: |A| = 0x80000000, |B| = 1, signs
    // agree, so LO = 0x80000000 and HI = 0 with no special case.
    logic [31:0] abs_a, abs_b, uq_s, ur_s, q_s, r_s;
    logic [31:0] q_u, r_u;

    assign abs_a = A[31] ? (~A + 32'd1) : A;
    assign abs_b = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    assign uq_s  = abs_a / abs_b;
    assign ur_s  = abs_a % abs_b;
    assign q_s   = (A[31] ^ b_safe[31]) ? (~uq_s + 32'd1) : uq_s;
    assign r_s   = A[31] ? (~ur_s + 32'd1) : ur_s;

    assign q_u   = A / b_safe;
    assign r_u   = A % b_safe;

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    case (mdu_op_e'(op))
                        OP_MULT: begin
                            pend_nxt  = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
                            cnt_nxt   = MUL_LOAD;
                            state_nxt = MUL_BUSY;
                        end
                        OP_MULTU: begin
                            pend_nxt  = '{wr: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
                            cnt_nxt   = MUL_LOAD;
                            state_nxt = MUL_BUSY;
                        end
                        OP_DIV: begin
                            pend_nxt  = '{wr: ~div_zero, hi: r_s, lo: q_s};
                            cnt_nxt   = DIV_LOAD;
                            state_nxt = DIV_BUSY;
                        end
                        OP_DIVU: begin
                            pend_nxt  = '{wr: ~div_zero, hi: r_u, lo: q_u};
                            cnt_nxt   = DIV_LOAD;
                            state_nxt = DIV_BUSY;
                        end
                        OP_MTHI: hi_nxt = A;
                        OP_MTLO: lo_nxt = A;
                        default: ;  // undefined op: stay idle, no effect
                    endcase
                end
            end

            MUL_BUSY, DIV_BUSY: begin
                // cnt holds the number of busy cycles remaining including
                // this one; the last one commits and drops back to IDLE.
                if (cnt <= CNT_ONE) begin
                    if (pend.wr) begin
                        hi_nxt = pend.hi;
                        lo_nxt = pend.lo;
                    end
                    pend_nxt.wr = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit. Each issued MULT/DIV pushes its
// expected HI/LO and busy length; a negedge monitor measures the busy run,
// checks HI/LO stay put during it, and pops/compares when busy falls.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2,
                           DIVU = 3'd3, MTHI  = 3'd4, MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          checks = 0, errors = 0;
    int          run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, written with 64-bit arithmetic rather than magnitudes.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output exp_t e);
        longint sx, sy, sq, sr, sp;
        logic [63:0] up;
        e.hi = m_hi; e.lo = m_lo; e.cycles = 0;
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        case (o)
            MULT:  begin sp = sx * sy; e.hi = sp[63:32]; e.lo = sp[31:0]; e.cycles = MC; end
            MULTU: begin up = {32'd0, x} * {32'd0, y}; e.hi = up[63:32]; e.lo = up[31:0]; e.cycles = MC; end
            DIV: begin
                e.cycles = DC;
                if (y != 0) begin
                    sq = sx / sy; sr = sx % sy;
                    e.lo = sq[31:0]; e.hi = sr[31:0];
                end
            end
            DIVU: begin
                e.cycles = DC;
                if (y != 0) begin e.lo = x / y; e.hi = x % y; end
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else if (busy) begin
            run++;
            chk("hold_hi", {32'd0, hi}, {32'd0, m_hi});
            chk("hold_lo", {32'd0, lo}, {32'd0, m_lo});
        end else if (run > 0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("busy_len", 64'(run), 64'(e.cycles));
                chk("res_hi", {32'd0, hi}, {32'd0, e.hi});
                chk("res_lo", {32'd0, lo}, {32'd0, e.lo});
                m_hi = e.hi; m_lo = e.lo;
            end
            run = 0;
        end
    end

    // Drive a request for one clock; MULT/DIV expectations go on the board,
    // MTHI/MTLO update the model directly.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        model(o, x, y, e);
        if (e.cycles != 0) sb.push_back(e);
        else if (o == MTHI) m_hi = x;
        else if (o == MTLO) m_lo = x;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_regs("reset");

        issue(MULT, 32'hFFFF_FFFF, 32'd2);   wait_idle();
        issue(MULTU, 32'hFFFF_FFFF, 32'd2);  wait_idle();
        issue(DIV, 32'hFFFF_FFF9, 32'd2);    wait_idle();
        issue(DIVU, 32'd7, 32'd2);           wait_idle();

        issue(MTHI, 32'h11, 32'd0);
        chk_regs("mthi");
        issue(MTLO, 32'h22, 32'd0);
        chk_regs("mtlo");
        issue(DIVU, 32'd5, 32'd0);           wait_idle();
        chk_regs("div0");
        issue(DIV, 32'd9, 32'd0);            wait_idle();

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(DIV, 32'd7, 32'hFFFF_FFFE);    wait_idle();
        issue(MULT, 32'h8000_0000, 32'h8000_0000); wait_idle();

        // Start while busy is dropped.
        issue(MULT, 32'd3, 32'd4);
        @(posedge clk); #1;
        start = 1'b1; op = MULT; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        chk("ign_lo", {32'd0, lo}, 64'd12);

        // Back-to-back: next issue lands on the first idle cycle.
        issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0); wait_idle();
        issue(DIVU, 32'hDEAD_BEEF, 32'd1000);       wait_idle();
        issue(MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);  wait_idle();

        // Undefined op is a no-op.
        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        chk_regs("undef6");
        issue(3'd7, 32'h5555_5555, 32'd1);
        chk_regs("undef7");

        // Reset on busy cycle 4 of a divide.
        issue(DIV, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        chk_regs("abort");
        issue(MULTU, 32'd2, 32'd3);          wait_idle();
        chk("post_abort_lo", {32'd0, lo}, 64'd6);

        // Reset wins over a simultaneous start.
        issue(MTHI, 32'h77, 32'd0);
        reset = 1'b1; start = 1'b1; op = MULT; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        m_hi = '0; m_lo = '0;
        chk_regs("rst_prio");
        @(negedge clk);
        chk("rst_prio_busy2", 64'(busy), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to issue op.
REQ-006 SHALL have port op, input, 3, operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A, input, 32, first operand, taken from GRF RD1.
REQ-008 SHALL have port B, input, 32, second operand, taken from GRF RD2.
REQ-009 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-010 SHALL have port HI, output, 32, HI register.
REQ-011 SHALL have port LO, output, 32, LO register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL_BUSY, DIV_BUSY.
REQ-013 SHALL sample start, op, A and B only in IDLE; start while busy is ignored, with no queuing.
REQ-014 SHALL, for MULT/MULTU at edge N, latch the 64-bit product {HI,LO} (signed/unsigned), enter MUL_BUSY, and hold busy=1 for exactly MULT_CYCLES cycles.
REQ-015 SHALL, for DIV/DIVU at edge N, latch LO=quotient and HI=remainder, enter DIV_BUSY, and hold busy=1 for exactly DIV_CYCLES cycles.
REQ-016 SHALL make signed division truncate toward zero, with the remainder taking the sign of the dividend.
REQ-017 SHALL commit results to HI/LO on the same edge that busy falls; HI/LO hold their old values throughout busy.
REQ-018 SHALL implement MTHI/MTLO with start in IDLE by writing A to HI/LO at that edge, with no busy cycle.
REQ-019 SHALL treat DIV/DIVU with B=0 as running the full busy period and leaving HI/LO unchanged.
REQ-020 SHALL treat DIV 0x80000000/0xFFFFFFFF as giving LO=0x80000000, HI=0.
REQ-021 SHALL use a busy-cycle counter of width clog2(max(MULT_CYCLES,DIV_CYCLES))+1 that counts down to 1, then returns the FSM to IDLE.
REQ-022 SHALL accept a new start in the cycle after busy falls; back-to-back operations have no extra bubble.
REQ-023 SHALL treat an undefined op with start as a no-op that stays in IDLE.

Reset
REQ-024 SHALL, when reset is high at an edge, set HI=0, LO=0, busy=0, counter=0, state=IDLE.
REQ-025 SHALL abort any in-flight operation on reset, discarding its latched result.
REQ-026 SHALL give reset priority over start when both are high at the same edge.

Structure
REQ-027 SHALL take op encodings and default latency constants from a shared package, mdu_pkg.
REQ-028 SHALL hold the IDLE/MUL_BUSY/DIV_BUSY state enumeration in mdu_pkg.
REQ-029 SHALL be a single module with no sub-module; arithmetic is combinational into pending-result registers, and timing comes from the counter.

Verification
REQ-030 SHALL cover: MULT A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-033 SHALL cover: DIVU A=5, B=0 after MTHI 0x11 / MTLO 0x22 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-034 SHALL cover: MULT A=3, B=4, then start MULT A=5, B=5 on busy cycle 2 -> second request ignored, final LO=12, HI=0.
REQ-035 SHALL cover: DIV issued, reset on busy cycle 4 -> next cycle busy=0, HI=0, LO=0; a new MULTU 2*3 then gives LO=6.
